butterfly_radix4_pipe: RTL and testbench

//  Pipelined radix-4 DIT butterfly, the compute element of the 64-point radix-4 FFT stage.

---
 rtl/butterfly_radix4_pkg.sv | 35 +++
 rtl/butterfly_radix4_pipe_if.sv | 29 ++
 rtl/butterfly_radix4_pipe_cmul.sv | 34 +++
 rtl/butterfly_radix4_pipe.sv | 106 ++++++++++
 tb/tb_butterfly_radix4_pipe.sv | 132 +++++++++++++
 5 files changed

// File: rtl/butterfly_radix4_pkg.sv
// Shared types, widths and the DATA_W reduction helper for the radix-4 butterfly.
// Build option: BFLY_SAT_EN selects saturating reduction instead of two's-complement wrap.
package butterfly_radix4_pkg;

  localparam int DATA_W  = 32;
  localparam int TW_W    = 16;
  localparam int TW_FRAC = 14;
  localparam int ACC_W   = DATA_W + 2;
  localparam int WIDE_W  = 64;

  typedef logic signed [DATA_W-1:0] data_t;
  typedef logic signed [TW_W-1:0]   tw_t;
  typedef logic signed [ACC_W-1:0]  acc_t;
  typedef logic signed [WIDE_W-1:0] wide_t;

  typedef struct packed {
    data_t re;
    data_t im;
  } cplx_t;

  localparam wide_t DATA_MAX = (wide_t'(1) <<< (DATA_W - 1)) - wide_t'(1);
  localparam wide_t DATA_MIN = -(wide_t'(1) <<< (DATA_W - 1));

  // Callers sign-extend their intermediate to WIDE_W before reducing.
  function automatic data_t reduce_to_data(input wide_t v);
`ifdef BFLY_SAT_EN
    if (v > DATA_MAX)      return data_t'(DATA_MAX);
    else if (v < DATA_MIN) return data_t'(DATA_MIN);
    else                   return data_t'(v);
`else
    return data_t'(v);
`endif
  endfunction

endpackage

// File: rtl/butterfly_radix4_pipe_if.sv
// Sample-set bus of the radix-4 butterfly: inputs, twiddles and outputs with valids.
// Build option BFLY_SAT_EN does not affect this interface.
interface butterfly_radix4_if;
  import butterfly_radix4_pkg::*;

  logic  in_valid;
  logic  real_mode;
  data_t x0_re, x0_im, x1_re, x1_im, x2_re, x2_im, x3_re, x3_im;
  tw_t   w1_re, w1_im, w2_re, w2_im, w3_re, w3_im;
  logic  out_valid;
  data_t y0_re, y0_im, y1_re, y1_im, y2_re, y2_im, y3_re, y3_im;

  modport master (
    output in_valid, real_mode,
    output x0_re, x0_im, x1_re, x1_im, x2_re, x2_im, x3_re, x3_im,
    output w1_re, w1_im, w2_re, w2_im, w3_re, w3_im,
    input  out_valid,
    input  y0_re, y0_im, y1_re, y1_im, y2_re, y2_im, y3_re, y3_im
  );

  modport slave (
    input  in_valid, real_mode,
    input  x0_re, x0_im, x1_re, x1_im, x2_re, x2_im, x3_re, x3_im,
    input  w1_re, w1_im, w2_re, w2_im, w3_re, w3_im,
    output out_valid,
    output y0_re, y0_im, y1_re, y1_im, y2_re, y2_im, y3_re, y3_im
  );

endinterface

// File: rtl/butterfly_radix4_pipe_cmul.sv
// bfly_cmul: combinational x*W with full-precision products, floor shift by TW_FRAC, reduce.
// Build option BFLY_SAT_EN makes the final reduction saturate.
module bfly_cmul
  import butterfly_radix4_pkg::*;
(
  input  data_t x_re,
  input  data_t x_im,
  input  tw_t   w_re,
  input  tw_t   w_im,
  output data_t a_re,
  output data_t a_im
);

  localparam int PROD_W = DATA_W + TW_W;
  localparam int SUM_W  = PROD_W + 1;

  logic signed [PROD_W-1:0] p_rr, p_ii, p_ri, p_ir;
  logic signed [SUM_W-1:0]  s_re, s_im, sh_re, sh_im;

  always_comb begin
    p_rr  = PROD_W'(x_re) * PROD_W'(w_re);
    p_ii  = PROD_W'(x_im) * PROD_W'(w_im);
    p_ri  = PROD_W'(x_re) * PROD_W'(w_im);
    p_ir  = PROD_W'(x_im) * PROD_W'(w_re);
    s_re  = SUM_W'(p_rr) - SUM_W'(p_ii);
    s_im  = SUM_W'(p_ri) + SUM_W'(p_ir);
    // Arithmetic shift floors toward -inf; no rounding term is added.
    sh_re = s_re >>> TW_FRAC;
    sh_im = s_im >>> TW_FRAC;
    a_re  = reduce_to_data(wide_t'(sh_re));
    a_im  = reduce_to_data(wide_t'(sh_im));
  end

endmodule

// File: rtl/butterfly_radix4_pipe.sv
// Two-stage pipelined radix-4 DIT butterfly (complex with twiddles, or real first-stage mode).
// Build option BFLY_SAT_EN: all reductions to DATA_W saturate instead of wrapping.
module butterfly_radix4_pipe
  import butterfly_radix4_pkg::*;
(
  input  logic clk,
  input  logic rst,
  butterfly_radix4_if.slave bus
);

  data_t cm_re [1:3];
  data_t cm_im [1:3];

  cplx_t [3:0] a_p1_d, a_p1_q;
  logic        vld_p1_d, vld_p1_q;
  logic        real_p1_d, real_p1_q;

  cplx_t [3:0] y_p2_d, y_p2_q;
  logic        vld_p2_d, vld_p2_q;

  acc_t ar [4];
  acc_t ai [4];
  acc_t s_re [4];
  acc_t s_im [4];

  bfly_cmul u_cmul1 (.x_re(bus.x1_re), .x_im(bus.x1_im), .w_re(bus.w1_re), .w_im(bus.w1_im),
                     .a_re(cm_re[1]), .a_im(cm_im[1]));
  bfly_cmul u_cmul2 (.x_re(bus.x2_re), .x_im(bus.x2_im), .w_re(bus.w2_re), .w_im(bus.w2_im),
                     .a_re(cm_re[2]), .a_im(cm_im[2]));
  bfly_cmul u_cmul3 (.x_re(bus.x3_re), .x_im(bus.x3_im), .w_re(bus.w3_re), .w_im(bus.w3_im),
                     .a_re(cm_re[3]), .a_im(cm_im[3]));

  // Stage 1: twiddled a0..a3 (real mode drops all imaginary inputs and twiddles)
  always_comb begin
    a_p1_d    = '0;
    vld_p1_d  = bus.in_valid;
    real_p1_d = bus.real_mode;
    if (bus.real_mode) begin
      a_p1_d[0].re = bus.x0_re;
      a_p1_d[1].re = bus.x1_re;
      a_p1_d[2].re = bus.x2_re;
      a_p1_d[3].re = bus.x3_re;
    end else begin
      a_p1_d[0].re = bus.x0_re;
      a_p1_d[0].im = bus.x0_im;
      for (int k = 1; k < 4; k++) begin
        a_p1_d[k].re = cm_re[k];
        a_p1_d[k].im = cm_im[k];
      end
    end
  end

  // Stage 2: 4-point forward DFT at ACC_W bits, j*(r+ji) = -i + jr
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      ar[k] = acc_t'(a_p1_q[k].re);
      ai[k] = acc_t'(a_p1_q[k].im);
    end
    s_re[0] = ar[0] + ar[1] + ar[2] + ar[3];
    s_im[0] = ai[0] + ai[1] + ai[2] + ai[3];
    s_re[1] = ar[0] + ai[1] - ar[2] - ai[3];
    s_im[1] = ai[0] - ar[1] - ai[2] + ar[3];
    s_re[2] = ar[0] - ar[1] + ar[2] - ar[3];
    s_im[2] = ai[0] - ai[1] + ai[2] - ai[3];
    s_re[3] = ar[0] - ai[1] - ar[2] + ai[3];
    s_im[3] = ai[0] + ar[1] - ai[2] - ar[3];
    y_p2_d = '0;
    for (int k = 0; k < 4; k++) begin
      y_p2_d[k].re = reduce_to_data(wide_t'(s_re[k]));
      y_p2_d[k].im = reduce_to_data(wide_t'(s_im[k]));
    end
    // Real inputs make y0/y2 purely real; pin them so no residue can leak through.
    if (real_p1_q) begin
      y_p2_d[0].im = '0;
      y_p2_d[2].im = '0;
    end
    vld_p2_d = vld_p1_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_p1_q    <= '0;
      vld_p1_q  <= 1'b0;
      real_p1_q <= 1'b0;
      y_p2_q    <= '0;
      vld_p2_q  <= 1'b0;
    end else begin
      a_p1_q    <= a_p1_d;
      vld_p1_q  <= vld_p1_d;
      real_p1_q <= real_p1_d;
      y_p2_q    <= y_p2_d;
      vld_p2_q  <= vld_p2_d;
    end
  end

  assign bus.out_valid = vld_p2_q;
  assign bus.y0_re     = y_p2_q[0].re;
  assign bus.y0_im     = y_p2_q[0].im;
  assign bus.y1_re     = y_p2_q[1].re;
  assign bus.y1_im     = y_p2_q[1].im;
  assign bus.y2_re     = y_p2_q[2].re;
  assign bus.y2_im     = y_p2_q[2].im;
  assign bus.y3_re     = y_p2_q[3].re;
  assign bus.y3_im     = y_p2_q[3].im;

endmodule

// File: tb/tb_butterfly_radix4_pipe.sv
// Directed-vector bench for butterfly_radix4_pipe with hand-computed expectations.
// Expectations for the overflow vector follow BFLY_SAT_EN when it is defined.
module tb_butterfly_radix4_pipe;
  import butterfly_radix4_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  butterfly_radix4_if bus ();

  butterfly_radix4_pipe dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic vld, input logic rm,
                      input data_t x0r, input data_t x0i, input data_t x1r, input data_t x1i,
                      input data_t x2r, input data_t x2i, input data_t x3r, input data_t x3i,
                      input tw_t w1r, input tw_t w1i, input tw_t w2r, input tw_t w2i,
                      input tw_t w3r, input tw_t w3i);
    bus.in_valid  = vld;
    bus.real_mode = rm;
    bus.x0_re = x0r; bus.x0_im = x0i; bus.x1_re = x1r; bus.x1_im = x1i;
    bus.x2_re = x2r; bus.x2_im = x2i; bus.x3_re = x3r; bus.x3_im = x3i;
    bus.w1_re = w1r; bus.w1_im = w1i; bus.w2_re = w2r; bus.w2_im = w2i;
    bus.w3_re = w3r; bus.w3_im = w3i;
  endtask

  task automatic idle();
    load(1'b0, 1'b0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic expect_y(input string tag, input logic v,
                          input data_t y0r, input data_t y0i, input data_t y1r, input data_t y1i,
                          input data_t y2r, input data_t y2i, input data_t y3r, input data_t y3i);
    chk({tag, "_vld"},  {63'd0, bus.out_valid}, {63'd0, v});
    chk({tag, "_y0re"}, bus.y0_re, y0r);
    chk({tag, "_y0im"}, bus.y0_im, y0i);
    chk({tag, "_y1re"}, bus.y1_re, y1r);
    chk({tag, "_y1im"}, bus.y1_im, y1i);
    chk({tag, "_y2re"}, bus.y2_re, y2r);
    chk({tag, "_y2im"}, bus.y2_im, y2i);
    chk({tag, "_y3re"}, bus.y3_re, y3r);
    chk({tag, "_y3im"}, bus.y3_im, y3i);
  endtask

  initial begin
    data_t big;
    data_t y0_exp;
    big = 32'h7FFF_FFFF;
`ifdef BFLY_SAT_EN
    y0_exp = 32'h7FFF_FFFF;
`else
    y0_exp = 32'hFFFF_FFFC;
`endif

    rst = 1'b1;
    load(1'b1, 1'b0, 9, 9, 9, 9, 9, 9, 9, 9, 16384, 0, 16384, 0, 16384, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    idle();
    expect_y("reset", 1'b0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Real mode 1,2,3,4; imaginary inputs and twiddles are junk that must be ignored
    @(negedge clk);
    load(1'b1, 1'b1, 1, 77, 2, -5, 3, 123, 4, 9, 100, 200, -300, 400, 5, 6);
    @(negedge clk);
    idle();
    chk("t1_lat1_vld", {63'd0, bus.out_valid}, 64'd0);
    @(negedge clk);
    expect_y("t1", 1'b1, 10, 0, -2, 2, -2, 0, -2, -2);

    // Unity twiddles, only x0 nonzero
    load(1'b1, 1'b0, 1, 1, 0, 0, 0, 0, 0, 0, 16384, 0, 16384, 0, 16384, 0);
    repeat (2) @(negedge clk);
    expect_y("t2", 1'b1, 1, 1, 1, 1, 1, 1, 1, 1);

    // W1 = -j on x1 = 100
    load(1'b1, 1'b0, 0, 0, 100, 0, 0, 0, 0, 0, 0, -16384, 16384, 0, 16384, 0);
    repeat (2) @(negedge clk);
    expect_y("t3", 1'b1, 0, -100, -100, 0, 0, 100, 100, 0);

    // Real-mode overflow of y0
    load(1'b1, 1'b1, big, 0, big, 0, big, 0, big, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    expect_y("t4", 1'b1, y0_exp, 0, 0, 0, 0, 0, 0, 0);

    // Back-to-back: A (W1=-1.0 exact), B (real), C (floor of +-1.5)
    load(1'b1, 1'b0, 10, 20, 5, -7, 0, 0, 0, 0, -16384, 0, 16384, 0, 16384, 0);
    @(negedge clk);
    load(1'b1, 1'b1, 10, 0, -3, 0, 6, 0, 8, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    expect_y("t5a", 1'b1, 5, 27, 17, 25, 15, 13, 3, 15);
    load(1'b1, 1'b0, 0, 0, 3, 0, -3, 0, 0, 0, 8192, 0, 8192, 0, 0, 0);
    @(negedge clk);
    expect_y("t5b", 1'b1, 21, 0, 4, 11, 11, 0, 4, -11);
    idle();
    @(negedge clk);
    expect_y("t5c", 1'b1, -1, 0, 2, -1, -3, 0, 2, 1);
    @(negedge clk);
    chk("t5_tail_vld", {63'd0, bus.out_valid}, 64'd0);

    // Reset while a vector sits in stage 1, another valid vector offered during reset
    load(1'b1, 1'b1, 1, 0, 2, 0, 3, 0, 4, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b1;
    load(1'b1, 1'b0, 7, 7, 0, 0, 0, 0, 0, 0, 16384, 0, 16384, 0, 16384, 0);
    @(negedge clk);
    rst = 1'b0;
    idle();
    expect_y("t6_e1", 1'b0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    expect_y("t6_e2", 1'b0, 0, 0, 0, 0, 0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
